video_timing_gen: RTL and testbench

Parametrised successor to the fixed-mode sync generator inside DynamicDisplay. It produces hSync/vSync/DE, pixel coordinates and end-of-line/end-of-frame strobes for any raster size and sync polarity. Start/stop is frame-gated through `run`. It sits between the pixel-clock domain and the pixel source / TMDS encoder, replacing the per-mode hard-coded `sync_inst`.

---
 rtl/video_timing_pkg.sv | 48 ++++
 rtl/video_pattern_bars.sv | 35 +++
 rtl/video_timing_gen.sv | 186 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared state type, timing presets and colour-bar table for video_timing_gen.
package video_timing_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // 1280x720p60
  localparam int unsigned P720_H_ACTIVE  = 1280;
  localparam int unsigned P720_H_FP      = 110;
  localparam int unsigned P720_H_SYNC    = 40;
  localparam int unsigned P720_H_BP      = 220;
  localparam int unsigned P720_V_ACTIVE  = 720;
  localparam int unsigned P720_V_FP      = 5;
  localparam int unsigned P720_V_SYNC    = 5;
  localparam int unsigned P720_V_BP      = 20;

  // 1920x1080p60
  localparam int unsigned P1080_H_ACTIVE = 1920;
  localparam int unsigned P1080_H_FP     = 88;
  localparam int unsigned P1080_H_SYNC   = 44;
  localparam int unsigned P1080_H_BP     = 148;
  localparam int unsigned P1080_V_ACTIVE = 1080;
  localparam int unsigned P1080_V_FP     = 4;
  localparam int unsigned P1080_V_SYNC   = 5;
  localparam int unsigned P1080_V_BP     = 36;

  // 640x480p60 (both syncs active-low)
  localparam int unsigned P480_H_ACTIVE  = 640;
  localparam int unsigned P480_H_FP      = 16;
  localparam int unsigned P480_H_SYNC    = 96;
  localparam int unsigned P480_H_BP      = 48;
  localparam int unsigned P480_V_ACTIVE  = 480;
  localparam int unsigned P480_V_FP      = 10;
  localparam int unsigned P480_V_SYNC    = 2;
  localparam int unsigned P480_V_BP      = 33;

  // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb_t [0:7] BAR_RGB = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_pattern_bars.sv
// Eight vertical colour bars decoded from the pixel x coordinate.
// Compiled only when VIDEO_TIMING_GEN_PATTERN_EN is defined.
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
module video_pattern_bars
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned HW       = 11
) (
  input  logic [HW-1:0] x,
  input  logic          de,
  output logic [7:0]    red_c,
  output logic [7:0]    green_c,
  output logic [7:0]    blue_c
);

  // Narrow rasters still get at least one pixel per bar
  localparam int unsigned BAR_W = ((H_ACTIVE / 8) == 0) ? 1 : (H_ACTIVE / 8);

  logic [31:0] bar_raw_c;
  logic [2:0]  bar_c;
  rgb_t        rgb_c;

  // Bar index saturates at the last bar; colours forced to black outside DE
  always_comb begin
    bar_raw_c = 32'(x) / BAR_W;
    bar_c     = (bar_raw_c > 32'd7) ? 3'd7 : bar_raw_c[2:0];
    rgb_c     = BAR_RGB[bar_c];
    red_c     = de ? rgb_c.r : 8'h00;
    green_c   = de ? rgb_c.g : 8'h00;
    blue_c    = de ? rgb_c.b : 8'h00;
  end

endmodule
`endif

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: syncs, DE, coordinates and line/frame
// strobes, started and stopped only on frame boundaries.
// Optional colour-bar source enabled by VIDEO_TIMING_GEN_PATTERN_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic          hSync,
  output logic          vSync,
  output logic          DE,
  output logic [HW-1:0] x_pos,
  output logic [VW-1:0] y_pos,
  output logic          EndLine,
  output logic          EndFrame,
  output logic          busy,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue
);

  localparam int unsigned   H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned   H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned   V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned   V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);

  // A zero-length interval would collapse the raster
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $fatal(1, "video_timing_gen: all timing parameters must be non-zero");
  end

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  logic          s1_act;
  logic [HW-1:0] s1_h;
  logic [VW-1:0] s1_v;

  logic de_c, hs_c, vs_c, el_c, ef_c;

  // State and raster counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Next state and counter advance; run is only honoured at the frame boundary
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            if (!run) state_d = IDLE;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot of the counters that the decode stage works from
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_act <= 1'b0;
      s1_h   <= '0;
      s1_v   <= '0;
    end else begin
      s1_act <= (state_q == RUN);
      s1_h   <= h_q;
      s1_v   <= v_q;
    end
  end

  // Raster decode of the snapshot; everything idles while not running
  always_comb begin
    de_c = 1'b0;
    hs_c = 1'b0;
    vs_c = 1'b0;
    el_c = 1'b0;
    ef_c = 1'b0;
    if (s1_act) begin
      de_c = (32'(s1_h) < H_ACTIVE) && (32'(s1_v) < V_ACTIVE);
      hs_c = (32'(s1_h) >= H_SYNC_START) && (32'(s1_h) < H_SYNC_END);
      vs_c = (32'(s1_v) >= V_SYNC_START) && (32'(s1_v) < V_SYNC_END);
      el_c = (s1_h == H_LAST);
      ef_c = el_c && (s1_v == V_LAST);
    end
  end

  // Output register keeps syncs, DE, coordinates and strobes mutually aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hSync    <= ~HS_POL;
      vSync    <= ~VS_POL;
      DE       <= 1'b0;
      x_pos    <= '0;
      y_pos    <= '0;
      EndLine  <= 1'b0;
      EndFrame <= 1'b0;
      busy     <= 1'b0;
    end else begin
      hSync    <= hs_c ? HS_POL : ~HS_POL;
      vSync    <= vs_c ? VS_POL : ~VS_POL;
      DE       <= de_c;
      x_pos    <= s1_act ? s1_h : '0;
      y_pos    <= s1_act ? s1_v : '0;
      EndLine  <= el_c;
      EndFrame <= ef_c;
      busy     <= s1_act;
    end
  end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  logic [7:0] pat_r_c, pat_g_c, pat_b_c;

  video_pattern_bars #(
    .H_ACTIVE (H_ACTIVE),
    .HW       (HW)
  ) u_bars (
    .x       (s1_h),
    .de      (de_c),
    .red_c   (pat_r_c),
    .green_c (pat_g_c),
    .blue_c  (pat_b_c)
  );

  // Pattern colours registered alongside DE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      red   <= 8'h00;
      green <= 8'h00;
      blue  <= 8'h00;
    end else begin
      red   <= pat_r_c;
      green <= pat_g_c;
      blue  <= pat_b_c;
    end
  end
`else
  assign red   = 8'h00;
  assign green = 8'h00;
  assign blue  = 8'h00;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a 16x8 raster, with a second
// instance using active-low syncs.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n;
  logic run;

  logic       hsync, vsync, de, el, ef, busy;
  logic [3:0] x_pos;
  logic [2:0] y_pos;
  logic [7:0] red, green, blue;

  logic       hsync_n, vsync_n, de_n, el_n, ef_n, busy_n;
  logic [3:0] x_pos_n;
  logic [2:0] y_pos_n;
  logic [7:0] red_n, green_n, blue_n;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: generator raster index (-1 = idle) and its 2-edge-late view at the outputs
  int ph0 = -1, ph1 = -1, ph2 = -1;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .reset(rst_n), .run(run),
    .hSync(hsync), .vSync(vsync), .DE(de),
    .x_pos(x_pos), .y_pos(y_pos),
    .EndLine(el), .EndFrame(ef), .busy(busy),
    .red(red), .green(green), .blue(blue)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .clk(clk), .reset(rst_n), .run(run),
    .hSync(hsync_n), .vSync(vsync_n), .DE(de_n),
    .x_pos(x_pos_n), .y_pos(y_pos_n),
    .EndLine(el_n), .EndFrame(ef_n), .busy(busy_n),
    .red(red_n), .green(green_n), .blue(blue_n)
  );

  function automatic int next_pos(input int p, input logic r);
    if (p < 0 || p == FRAME - 1) return r ? 0 : -1;
    return p + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph0 <= -1;
      ph1 <= -1;
      ph2 <= -1;
    end else begin
      ph0 <= next_pos(ph0, run);
      ph1 <= ph0;
      ph2 <= ph1;
    end
  end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  function automatic logic [23:0] bar_colour(input int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
`endif

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Compare both instances against the reference view of the outputs
  task automatic check_all(input string tag);
    int p, ex, ey, bar;
    logic e_de, e_hs, e_vs, e_el, e_ef, e_busy;
    logic [23:0] e_rgb;
    p = ph2;
    ex = 0; ey = 0;
    e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_el = 1'b0; e_ef = 1'b0; e_busy = 1'b0;
    if (p >= 0) begin
      ex     = p % HT;
      ey     = p / HT;
      e_de   = (ex < HA) && (ey < VA);
      e_hs   = (ex >= HA + HF) && (ex < HA + HF + HS);
      e_vs   = (ey >= VA + VF) && (ey < VA + VF + VS);
      e_el   = (ex == HT - 1);
      e_ef   = (p == FRAME - 1);
      e_busy = 1'b1;
    end
    e_rgb = 24'h0;
    bar = ex / (HA / 8);
    if (bar > 7) bar = 7;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    if (e_de) e_rgb = bar_colour(bar);
`endif
    chk({tag, ":DE"},      32'(de),    32'(e_de));
    chk({tag, ":hSync"},   32'(hsync), 32'(e_hs));
    chk({tag, ":vSync"},   32'(vsync), 32'(e_vs));
    chk({tag, ":x_pos"},   32'(x_pos), 32'(ex));
    chk({tag, ":y_pos"},   32'(y_pos), 32'(ey));
    chk({tag, ":EndLine"}, 32'(el),    32'(e_el));
    chk({tag, ":EndFrame"},32'(ef),    32'(e_ef));
    chk({tag, ":busy"},    32'(busy),  32'(e_busy));
    chk({tag, ":rgb"},     32'({red, green, blue}), 32'(e_rgb));
    chk({tag, ":hSync_n"}, 32'(hsync_n), 32'(!e_hs));
    chk({tag, ":vSync_n"}, 32'(vsync_n), 32'(!e_vs));
    chk({tag, ":n_misc"},  32'({de_n, el_n, ef_n, busy_n, x_pos_n, y_pos_n}),
                           32'({e_de, e_el, e_ef, e_busy, 4'(ex), 3'(ey)}));
    chk({tag, ":n_rgb"},   32'({red_n, green_n, blue_n}), 32'(e_rgb));
  endtask

  // Raise run from idle, check the 2-cycle start latency, then one full frame
  task automatic start_and_frame(input string tag);
    int de_c, hs_c, vs_c, hsl, vsl, ef_c, ef_at, el_c;
    de_c = 0; hs_c = 0; vs_c = 0; hsl = 0; vsl = 0; ef_c = 0; ef_at = -1; el_c = 0;
    run = 1'b1;
    @(negedge clk); check_all(tag); chk({tag, ":lat_e0_de"}, 32'(de), 32'd0);
    @(negedge clk); check_all(tag); chk({tag, ":lat_e1_de"}, 32'(de), 32'd0);
    @(negedge clk);
    chk({tag, ":lat_e2_de"}, 32'(de),    32'd1);
    chk({tag, ":lat_e2_x"},  32'(x_pos), 32'd0);
    chk({tag, ":lat_e2_y"},  32'(y_pos), 32'd0);
    for (int c = 0; c < FRAME; c++) begin
      if (c != 0) @(negedge clk);
      check_all(tag);
      if (de)       de_c++;
      if (hsync)    hs_c++;
      if (vsync)    vs_c++;
      if (!hsync_n) hsl++;
      if (!vsync_n) vsl++;
      if (el)       el_c++;
      if (ef) begin ef_c++; ef_at = c; end
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
      if (c == 0) chk({tag, ":pat_x0"}, 32'({red, green, blue}), 32'h00FFFFFF);
      if (c == 1) chk({tag, ":pat_x1"}, 32'({red, green, blue}), 32'h00FFFF00);
      if (c == 7) chk({tag, ":pat_x7"}, 32'({red, green, blue}), 32'h00000000);
      if (c == 9) chk({tag, ":pat_blank"}, 32'({red, green, blue}), 32'h00000000);
`endif
    end
    chk({tag, ":de_count"},    32'(de_c),  32'd32);
    chk({tag, ":hs_count"},    32'(hs_c),  32'd24);
    chk({tag, ":vs_count"},    32'(vs_c),  32'd32);
    chk({tag, ":hs_low_neg"},  32'(hsl),   32'd24);
    chk({tag, ":vs_low_neg"},  32'(vsl),   32'd32);
    chk({tag, ":el_count"},    32'(el_c),  32'd8);
    chk({tag, ":ef_count"},    32'(ef_c),  32'd1);
    chk({tag, ":ef_cycle"},    32'(ef_at), 32'd127);
  endtask

  initial begin
    int guard, ef_c, ef_at, fall_at, de_seen, hs_seen;

    // Reset state
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); check_all("idle"); end

    // Start latency and first frame, then seamless continuation
    start_and_frame("frame1");
    repeat (20) begin @(negedge clk); check_all("seamless"); end

    // Random run toggling; the reference decides when frames start and stop
    for (int blk = 0; blk < 16; blk++) begin
      run = ($urandom_range(0, 2) != 0);
      repeat ($urandom_range(10, 60)) begin @(negedge clk); check_all("random"); end
    end

    // Stop gating: drop run mid-frame at x=4, y=2
    run = 1'b1;
    guard = 0;
    while (ph2 != 2 * HT + 4 && guard < 400) begin
      @(negedge clk); check_all("stop_wait"); guard++;
    end
    chk("stop_reach_x", 32'(x_pos), 32'd4);
    chk("stop_reach_y", 32'(y_pos), 32'd2);
    run = 1'b0;
    ef_c = 0; ef_at = -1; fall_at = -1;
    for (int c = 0; c < 200 && fall_at < 0; c++) begin
      @(negedge clk); check_all("stop_drain");
      if (ef) begin ef_c++; ef_at = c; end
      if (!busy) fall_at = c;
    end
    chk("stop_ef_count", 32'(ef_c),    32'd1);
    chk("stop_ef_cycle", 32'(ef_at),   32'd90);
    chk("stop_busy_fall", 32'(fall_at), 32'(ef_at + 1));
    de_seen = 0; hs_seen = 0;
    repeat (40) begin
      @(negedge clk); check_all("stopped");
      if (de)    de_seen++;
      if (hsync) hs_seen++;
    end
    chk("stopped_de",    32'(de_seen), 32'd0);
    chk("stopped_hsync", 32'(hs_seen), 32'd0);

    // Restart from idle
    start_and_frame("restart");

    // Asynchronous reset mid-frame at y=3, x=5 between clock edges
    guard = 0;
    while (ph2 != 3 * HT + 5 && guard < 400) begin
      @(negedge clk); check_all("rst_wait"); guard++;
    end
    chk("rst_reach_x", 32'(x_pos), 32'd5);
    chk("rst_reach_y", 32'(y_pos), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_de",    32'(de),      32'd0);
    chk("async_rst_hs",    32'(hsync),   32'd0);
    chk("async_rst_hs_n",  32'(hsync_n), 32'd1);
    chk("async_rst_vs_n",  32'(vsync_n), 32'd1);
    chk("async_rst_xy",    32'({x_pos, y_pos}), 32'd0);
    chk("async_rst_busy",  32'(busy),    32'd0);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    start_and_frame("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
